// File: rtl/poly1305_block_sequencer_pkg.sv
// Shared types and helpers for the Poly1305 block sequencer.
package poly1305_block_sequencer_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_BITS  = BLOCK_BYTES * 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_KICK,
    S_AAD_IN,
    S_AAD_OUT,
    S_AAD_WAIT,
    S_PLD_IN,
    S_PLD_OUT,
    S_PLD_WAIT,
    S_LEN_OUT,
    S_LEN_WAIT,
    S_TAG_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_CFG        = 2'd0,
    ERR_EARLY_LAST = 2'd1,
    ERR_NO_LAST    = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } err_code_t;

  // Byte-enable mask with the low n bytes set (n saturates at BLOCK_BYTES).
  function automatic logic [BLOCK_BYTES-1:0] keep_from_count(input logic [4:0] n);
    logic [BLOCK_BYTES-1:0] k;
    for (int i = 0; i < BLOCK_BYTES; i++) k[i] = (5'(i) < n);
    return k;
  endfunction

endpackage

// File: rtl/poly1305_block_sequencer_block_masker.sv
// Turns a remaining-byte count into a block keep mask and zeroes the
// bytes past the end of the segment (pad16 zero fill).
module poly1305_block_sequencer_block_masker
  import poly1305_block_sequencer_pkg::*;
(
  input  logic [31:0]            rem,
  input  logic [BLOCK_BITS-1:0]  data_in,
  output logic [4:0]             count,
  output logic [BLOCK_BYTES-1:0] keep,
  output logic [BLOCK_BITS-1:0]  data_out
);

  // Bytes carried by this beat: min(rem, 16).
  always_comb count = (rem >= 32'(BLOCK_BYTES)) ? 5'(BLOCK_BYTES) : rem[4:0];

  assign keep = keep_from_count(count);

  for (genvar i = 0; i < BLOCK_BYTES; i++) begin : g_byte
    assign data_out[8*i +: 8] = keep[i] ? data_in[8*i +: 8] : 8'h00;
  end

endmodule

// File: rtl/poly1305_block_sequencer.sv
// Sequences one ChaCha20-Poly1305 MAC message: AAD blocks, payload blocks,
// then the length block, each gated on the engine's per-block done pulse.
module poly1305_block_sequencer
  import poly1305_block_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            aad_len,
  input  logic [31:0]            pld_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BLOCK_BITS-1:0]  in_data,
  input  logic                   in_last,
  output logic                   adp_start,
  output logic                   adp_algo_sel,
  output logic                   aad_valid,
  input  logic                   aad_ready,
  output logic [BLOCK_BITS-1:0]  aad_data,
  output logic [BLOCK_BYTES-1:0] aad_keep,
  output logic                   pld_valid,
  input  logic                   pld_ready,
  output logic [BLOCK_BITS-1:0]  pld_data,
  output logic [BLOCK_BYTES-1:0] pld_keep,
  output logic                   len_valid,
  input  logic                   len_ready,
  output logic [BLOCK_BITS-1:0]  len_block,
  input  logic                   aad_done,
  input  logic                   pld_done,
  input  logic                   lens_done,
  input  logic [BLOCK_BITS-1:0]  tag_in,
  input  logic                   tag_in_valid,
  output logic [BLOCK_BITS-1:0]  tag_out,
  output logic                   tag_valid,
  output logic                   busy,
  output logic                   err,
  output logic [1:0]             err_code
);

  state_t                 state, nxt;
  logic [31:0]            aad_len_q, pld_len_q, aad_rem, pld_rem, wd;
  logic [31:0]            seg_rem, rem_after;
  logic [4:0]             blk_cnt;
  logic [BLOCK_BYTES-1:0] blk_keep;
  logic [BLOCK_BITS-1:0]  blk_data;
  logic                   waiting, wd_hit, last_due, take, err_set;
  err_code_t              err_nxt;

  assign seg_rem   = (state == S_PLD_IN) ? pld_rem : aad_rem;
  assign rem_after = seg_rem - 32'(blk_cnt);
  // The beat that must carry in_last: end of payload, or end of AAD when there is no payload.
  assign last_due  = (rem_after == '0) && ((state == S_PLD_IN) || (pld_rem == '0));

  poly1305_block_sequencer_block_masker u_masker (
    .rem      (seg_rem),
    .data_in  (in_data),
    .count    (blk_cnt),
    .keep     (blk_keep),
    .data_out (blk_data)
  );

  assign waiting      = (state == S_AAD_WAIT) || (state == S_PLD_WAIT) ||
                        (state == S_LEN_WAIT) || (state == S_TAG_WAIT);
  assign wd_hit       = waiting && (wd == 32'(TIMEOUT_CYCLES - 1));
  assign in_ready     = (state == S_AAD_IN) || (state == S_PLD_IN);
  assign adp_algo_sel = 1'b1;

  // Next-state, error decode and block-capture strobe.
  always_comb begin
    nxt     = state;
    err_set = 1'b0;
    err_nxt = ERR_CFG;
    take    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        if (aad_len == '0) err_set = 1'b1;
        else               nxt = S_KICK;
      end
      S_KICK: nxt = S_AAD_IN;
      S_AAD_IN, S_PLD_IN: if (in_valid) begin
        if (in_last && rem_after != '0) begin
          err_set = 1'b1; err_nxt = ERR_EARLY_LAST; nxt = S_ERR;
        end else if (!in_last && last_due) begin
          err_set = 1'b1; err_nxt = ERR_NO_LAST; nxt = S_ERR;
        end else begin
          take = 1'b1;
          nxt  = (state == S_AAD_IN) ? S_AAD_OUT : S_PLD_OUT;
        end
      end
      S_AAD_OUT: if (aad_ready) nxt = S_AAD_WAIT;
      S_PLD_OUT: if (pld_ready) nxt = S_PLD_WAIT;
      S_AAD_WAIT: begin
        if (aad_done)    nxt = (aad_rem != '0) ? S_AAD_IN :
                               (pld_rem != '0) ? S_PLD_IN : S_LEN_OUT;
        else if (wd_hit) begin err_set = 1'b1; err_nxt = ERR_TIMEOUT; nxt = S_ERR; end
      end
      S_PLD_WAIT: begin
        if (pld_done)    nxt = (pld_rem != '0) ? S_PLD_IN : S_LEN_OUT;
        else if (wd_hit) begin err_set = 1'b1; err_nxt = ERR_TIMEOUT; nxt = S_ERR; end
      end
      S_LEN_OUT: if (len_ready) nxt = S_LEN_WAIT;
      S_LEN_WAIT: begin
        if (lens_done)   nxt = S_TAG_WAIT;
        else if (wd_hit) begin err_set = 1'b1; err_nxt = ERR_TIMEOUT; nxt = S_ERR; end
      end
      S_TAG_WAIT: begin
        if (tag_in_valid) nxt = S_DONE;
        else if (wd_hit)  begin err_set = 1'b1; err_nxt = ERR_TIMEOUT; nxt = S_ERR; end
      end
      S_DONE, S_ERR: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // Abort beats any handshake or error in the same cycle.
    if (abort && state != S_IDLE) begin
      nxt     = S_IDLE;
      err_set = 1'b0;
      take    = 1'b0;
    end
  end

  // State register and watchdog; the watchdog restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wd    <= '0;
    end else begin
      state <= nxt;
      wd    <= (nxt != state || !waiting) ? '0 : wd + 32'd1;
    end
  end

  // Length latches and per-segment remaining-byte counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aad_len_q <= '0;
      pld_len_q <= '0;
      aad_rem   <= '0;
      pld_rem   <= '0;
    end else if (state == S_IDLE && nxt == S_KICK) begin
      aad_len_q <= aad_len;
      pld_len_q <= pld_len;
      aad_rem   <= aad_len;
      pld_rem   <= pld_len;
    end else if (take) begin
      if (state == S_AAD_IN) aad_rem <= rem_after;
      else                   pld_rem <= rem_after;
    end
  end

  // Masked block registers; data/keep hold until the next accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aad_valid <= 1'b0;
      aad_data  <= '0;
      aad_keep  <= '0;
      pld_valid <= 1'b0;
      pld_data  <= '0;
      pld_keep  <= '0;
    end else begin
      aad_valid <= (nxt == S_AAD_OUT);
      pld_valid <= (nxt == S_PLD_OUT);
      if (take && state == S_AAD_IN) begin
        aad_data <= blk_data;
        aad_keep <= blk_keep;
      end
      if (take && state == S_PLD_IN) begin
        pld_data <= blk_data;
        pld_keep <= blk_keep;
      end
    end
  end

  // Engine kick, length block, tag capture, busy and error reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adp_start <= 1'b0;
      busy      <= 1'b0;
      len_valid <= 1'b0;
      len_block <= '0;
      tag_valid <= 1'b0;
      tag_out   <= '0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      adp_start <= (nxt == S_KICK);
      busy      <= (nxt != S_IDLE);
      len_valid <= (nxt == S_LEN_OUT);
      if (nxt == S_LEN_OUT && state != S_LEN_OUT)
        len_block <= {32'h0, pld_len_q, 32'h0, aad_len_q};
      tag_valid <= (state == S_TAG_WAIT) && (nxt == S_DONE);
      if (state == S_TAG_WAIT && nxt == S_DONE) tag_out <= tag_in;
      err <= err_set;
      if (err_set) err_code <= err_nxt;
    end
  end

endmodule

// File: tb/tb_poly1305_block_sequencer.sv
// Scoreboard bench: the stimulus process predicts blocks/len/tag/errors from
// the byte-length rules; an engine/monitor process pops and compares.
module tb_poly1305_block_sequencer;

  localparam int TO = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start, abort, in_valid, in_ready, in_last;
  logic [31:0] aad_len, pld_len;
  logic [127:0] in_data, aad_data, pld_data, len_block, tag_in, tag_out;
  logic [15:0] aad_keep, pld_keep;
  logic adp_start, adp_algo_sel, aad_valid, aad_ready, pld_valid, pld_ready;
  logic len_valid, len_ready, aad_done, pld_done, lens_done, tag_in_valid;
  logic tag_valid, busy, err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  poly1305_block_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .aad_len(aad_len), .pld_len(pld_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .adp_start(adp_start), .adp_algo_sel(adp_algo_sel),
    .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_data(aad_data), .aad_keep(aad_keep),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data), .pld_keep(pld_keep),
    .len_valid(len_valid), .len_ready(len_ready), .len_block(len_block),
    .aad_done(aad_done), .pld_done(pld_done), .lens_done(lens_done),
    .tag_in(tag_in), .tag_in_valid(tag_in_valid), .tag_out(tag_out), .tag_valid(tag_valid),
    .busy(busy), .err(err), .err_code(err_code)
  );

  typedef struct { logic [127:0] data; logic [15:0] keep; } blk_t;

  blk_t         aad_q[$], pld_q[$];
  logic [127:0] len_q[$], tag_q[$];
  int           err_q[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int adp_cnt = 0, pv_cnt = 0, tag_cnt = 0, err_cnt = 0, busy_cnt = 0, vld_cnt = 0;
  int hs_aad_cyc = 0, err_cyc = 0;
  bit pld_stall = 0, hold_aad_done = 0, busy_drop_chk = 0;
  logic [127:0] cur_tag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    total++; bad++;
    $display("FAIL %s: DUT output with nothing expected", name);
  endtask

  // Length block: aad_len as 64-bit LE in bytes 0..7, pld_len in bytes 8..15.
  function automatic logic [127:0] len_exp(input logic [31:0] a, input logic [31:0] p);
    logic [127:0] v = '0;
    logic [63:0] a64 = {32'h0, a}, p64 = {32'h0, p};
    for (int i = 0; i < 8; i++) begin
      v[8*i +: 8]      = a64[8*i +: 8];
      v[64 + 8*i +: 8] = p64[8*i +: 8];
    end
    return v;
  endfunction

  // Engine model plus output monitor.
  initial begin
    int ca, cp, cl, ct;
    blk_t e;
    ca = 0; cp = 0; cl = 0; ct = 0;
    aad_ready = 0; pld_ready = 0; len_ready = 0;
    aad_done = 0; pld_done = 0; lens_done = 0; tag_in_valid = 0; tag_in = '0;
    forever begin
      @(negedge clk);
      aad_ready = ($urandom % 4) != 0;
      pld_ready = pld_stall ? 1'b0 : (($urandom % 4) != 0);
      len_ready = ($urandom % 3) != 0;
      aad_done = 0; pld_done = 0; lens_done = 0; tag_in_valid = 0;
      if (ca > 0) begin ca--; if (ca == 0) aad_done = 1; end
      if (cp > 0) begin cp--; if (cp == 0) pld_done = 1; end
      if (ct > 0) begin ct--; if (ct == 0) begin tag_in_valid = 1; tag_in = cur_tag; end end
      if (cl > 0) begin cl--; if (cl == 0) begin lens_done = 1; ct = 1 + int'($urandom % 5); end end
      #1;
      if (!rst_n) continue;
      if (busy_drop_chk) begin chk("busy_after_done", busy, 0); busy_drop_chk = 0; end
      if (adp_start) adp_cnt++;
      if (pld_valid) pv_cnt++;
      if (busy) busy_cnt++;
      if (aad_valid || pld_valid || len_valid) vld_cnt++;
      if (aad_valid && aad_ready) begin
        if (aad_q.size() == 0) miss("aad_block");
        else begin e = aad_q.pop_front(); chk("aad_data", aad_data, e.data); chk("aad_keep", aad_keep, e.keep); end
        hs_aad_cyc = cyc;
        if (!hold_aad_done) ca = 1 + int'($urandom % 5);
      end
      if (pld_valid && pld_ready) begin
        if (pld_q.size() == 0) miss("pld_block");
        else begin e = pld_q.pop_front(); chk("pld_data", pld_data, e.data); chk("pld_keep", pld_keep, e.keep); end
        cp = 1 + int'($urandom % 5);
      end
      if (len_valid && len_ready) begin
        if (len_q.size() == 0) miss("len_block");
        else chk("len_block", len_block, len_q.pop_front());
        cl = 1 + int'($urandom % 4);
      end
      if (tag_valid) begin
        tag_cnt++;
        if (tag_q.size() == 0) miss("tag");
        else chk("tag_out", tag_out, tag_q.pop_front());
        chk("busy_in_done", busy, 1);
        busy_drop_chk = 1;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
        if (err_q.size() == 0) miss("err");
        else chk("err_code", err_code, 128'(err_q.pop_front()));
      end
    end
  end

  task automatic send_start(input logic [31:0] a, input logic [31:0] p, input bit restart);
    @(negedge clk); aad_len = a; pld_len = p; start = 1;
    @(negedge clk); start = 0;
    if (restart) begin
      // Second start while busy, with an illegal length that must be ignored.
      start = 1; aad_len = 0;
      @(negedge clk); start = 0; aad_len = a;
    end
  endtask

  // mode: 0 normal, 1 withhold aad_done (timeout), 2 abort while pld_valid stalls.
  task automatic run_msg(input int a, input int p, input int mode, input bit ff,
                         input int early_beat, input bit drop_last, input bit restart);
    int adp0, tag0, err0, pv0, busy0, vld0, na, np, nb, lim, w, pld_pushed;
    bit errd;
    adp0 = adp_cnt; tag0 = tag_cnt; err0 = err_cnt; pv0 = pv_cnt; busy0 = busy_cnt; vld0 = vld_cnt;
    na = (a + 15) / 16; np = (p + 15) / 16; nb = na + np;
    lim = (mode == 2) ? na + 1 : nb;
    errd = 0; pld_pushed = 0;
    cur_tag = {$urandom, $urandom, $urandom, $urandom};
    hold_aad_done = (mode == 1);
    pld_stall = (mode == 2);
    if (a == 0) err_q.push_back(0);
    send_start(32'(a), 32'(p), restart);
    for (int b = 0; b < lim && a != 0 && !errd; b++) begin
      bit seg_aad, last;
      int rem, n, after;
      logic [127:0] d;
      blk_t e;
      seg_aad = (b < na);
      rem = seg_aad ? a - 16*b : p - 16*(b - na);
      n = (rem > 16) ? 16 : rem;
      after = rem - n;
      last = (b == nb - 1);
      if (drop_last && b == nb - 1) last = 0;
      if (b == early_beat) last = 1;
      d = ff ? '1 : {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1; in_data = d; in_last = last;
      w = 0;
      while (!in_ready && w < 300) begin @(negedge clk); w++; end
      if (w >= 300) begin
        total++; bad++;
        $display("FAIL in_ready_wait: got 0 expected 1 within 300 cycles");
        errd = 1;
      end else if (last && after > 0) begin
        err_q.push_back(1); errd = 1;
      end else if (!last && after == 0 && (!seg_aad || p == 0)) begin
        err_q.push_back(2); errd = 1;
      end else begin
        e.data = '0; e.keep = '0;
        for (int i = 0; i < 16; i++) if (i < n) begin e.keep[i] = 1'b1; e.data[8*i +: 8] = d[8*i +: 8]; end
        if (seg_aad) aad_q.push_back(e);
        else begin pld_q.push_back(e); pld_pushed++; end
      end
      @(negedge clk); in_valid = 0; in_last = 0;
      if (errd && w < 300) begin
        chk("err_pulse_on_bad_last", err, 1);
        @(negedge clk);
        chk("idle_two_cycles_after_bad_last", busy, 0);
      end
    end
    if (!errd && a != 0) begin
      if (mode == 1) err_q.push_back(3);
      else if (mode == 0) begin len_q.push_back(len_exp(32'(a), 32'(p))); tag_q.push_back(cur_tag); end
    end
    if (mode == 2 && !errd) begin
      w = 0;
      while (!pld_valid && w < 300) begin @(negedge clk); w++; end
      chk("pld_valid_before_abort", pld_valid, 1);
      abort = 1;
      @(negedge clk); abort = 0;
      chk("pld_valid_after_abort", pld_valid, 0);
      chk("busy_after_abort", busy, 0);
      pld_q.delete();
    end
    w = 0;
    while (busy && w < 400) begin @(negedge clk); w++; end
    chk("message_ends", busy, 0);
    repeat (4) @(negedge clk);
    chk("adp_start_count", 128'(adp_cnt - adp0), (a != 0) ? 1 : 0);
    chk("tag_valid_count", 128'(tag_cnt - tag0), (mode == 0 && !errd && a != 0) ? 1 : 0);
    chk("err_count", 128'(err_cnt - err0), (errd || mode == 1 || a == 0) ? 1 : 0);
    chk("pld_valid_seen", 128'(pv_cnt != pv0), 128'(pld_pushed != 0));
    chk("queues_drained", 128'(aad_q.size() + pld_q.size() + len_q.size() + tag_q.size() + err_q.size()), 0);
    if (a == 0) begin
      chk("cfg_err_busy_stays_low", 128'(busy_cnt - busy0), 0);
      chk("cfg_err_valids_stay_low", 128'(vld_cnt - vld0), 0);
    end
    hold_aad_done = 0; pld_stall = 0;
    aad_q.delete(); pld_q.delete(); len_q.delete(); tag_q.delete(); err_q.delete();
  endtask

  initial begin
    int a, p, r, nb, eb;
    bit dl;
    start = 0; abort = 0; aad_len = 0; pld_len = 0;
    in_valid = 0; in_data = '0; in_last = 0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_adp_start", adp_start, 0);
    chk("rst_algo_sel", adp_algo_sel, 1);
    chk("rst_valids", {aad_valid, pld_valid, len_valid, tag_valid, err}, 0);
    chk("rst_keeps", {aad_keep, pld_keep}, 0);
    chk("rst_data", aad_data | pld_data | len_block | tag_out, 0);
    chk("rst_err_code", err_code, 0);
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);

    run_msg(16, 32, 0, 0, -1, 0, 1);   // full blocks, start-while-busy ignored
    run_msg(5, 20, 0, 1, -1, 0, 0);    // partial-block masking on all-FF data
    run_msg(0, 7, 0, 0, -1, 0, 0);     // aad_len == 0 config error
    run_msg(16, 32, 0, 0, 1, 0, 0);    // in_last on first payload beat
    run_msg(16, 0, 1, 0, -1, 0, 0);    // aad_done withheld
    chk("timeout_latency", 128'(err_cyc - (hs_aad_cyc + 1)), TO);
    run_msg(16, 32, 2, 0, -1, 0, 0);   // abort while pld_valid stalls
    run_msg(16, 32, 0, 0, -1, 0, 0);   // normal message after abort
    run_msg(33, 0, 0, 0, -1, 0, 0);    // AAD-only message
    run_msg(7, 17, 0, 0, -1, 1, 0);    // missing in_last

    for (int k = 0; k < 20; k++) begin
      a = 1 + int'($urandom % 60);
      p = int'($urandom % 61);
      nb = (a + 15) / 16 + (p + 15) / 16;
      r = int'($urandom % 8);
      dl = (r == 0);
      eb = (r == 1) ? int'($urandom % nb) : -1;
      run_msg(a, p, 0, ($urandom % 4) == 0, eb, dl, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/poly1305_block_sequencer.md
# poly1305_block_sequencer

Controller that sequences the ChaCha20-Poly1305 MAC datapath for one message. It takes a configured AAD length and payload length plus a 128-bit beat stream, cuts the stream into AAD and payload blocks, and zero-masks partial blocks (RFC 8439 pad16). It builds the 16-byte length block and drives the MAC engine's AAD/payload/length handshakes one block at a time, gated on the engine's per-block done pulses. It sits between the host-side DMA/cfg logic and the Poly1305 adapter, captures the tag, and adds abort and watchdog error handling.

## Interface
- TIMEOUT_CYCLES, default 1024: max cycles waiting for a done pulse or tag before error.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; begin message (ignored unless IDLE).
- abort  in  1  pulse; cancel current message.
- aad_len  in  32  AAD length in bytes; latched on start.
- pld_len  in  32  payload length in bytes; latched on start.
- in_valid / in_ready  in / out  1  upstream beat handshake.
- in_data  in  128  beat, byte 0 at [7:0].
- in_last  in  1  marks final beat of message.
- adp_start, adp_algo_sel  out  1  start pulse to engine; algo_sel constant 1.
- aad_valid / aad_ready  out / in  1  AAD block handshake.
- aad_data, aad_keep  out  128, 16  masked AAD block and keep.
- pld_valid / pld_ready, pld_data, pld_keep: same for payload.
- len_valid / len_ready  out / in  1; len_block  out  128.
- aad_done, pld_done, lens_done  in  1  per-block completion pulses.
- tag_in, tag_in_valid  in  128, 1  engine tag result.
- tag_out  out  128  captured tag; tag_valid  out  1  one-cycle pulse.
- busy  out  1  high from the cycle after accepted start until DONE/ERR exit.
- err  out  1  one-cycle pulse; err_code  out  2  0 cfg, 1 early in_last, 2 missing in_last, 3 timeout.

## Operation
- States: IDLE, KICK, AAD_IN, AAD_OUT, AAD_WAIT, PLD_IN, PLD_OUT, PLD_WAIT, LEN_OUT, LEN_WAIT, TAG_WAIT, DONE, ERR.
- IDLE + start:
  - aad_len==0: err, code 0, stay IDLE, no adp_start.
  - Otherwise latch lengths into down-counters aad_rem/pld_rem and go to KICK.
- KICK: adp_start=1 for one cycle, then AAD_IN.
- x_IN: in_ready=1. On handshake, register the block.
  - n = min(rem,16); keep = (1<<n)-1; data bytes ≥ n forced to 0.
  - rem -= n; go to x_OUT.
- x_OUT: hold valid/data/keep stable until ready, then go to x_WAIT.
- x_WAIT: on done pulse:
  - rem>0: back to x_IN.
  - AAD finished: go to PLD_IN if pld_len>0, else LEN_OUT.
  - PLD finished: go to LEN_OUT.
- in_last rules:
  - in_last on a beat with rem after decrement >0, in either segment: err code 1.
  - Final payload beat, or final AAD beat when pld_len==0, without in_last: err code 2.
  - Both error checks are evaluated at the in handshake; the block is not forwarded.
- LEN_OUT: len_block = {32'h0, pld_len, 32'h0, aad_len} (aad_len LE in bytes 0-7, pld_len LE in bytes 8-15). After handshake go to LEN_WAIT; lens_done moves to TAG_WAIT.
- TAG_WAIT: on tag_in_valid, capture tag_out, pulse tag_valid, go to DONE. DONE returns to IDLE next cycle.
- Watchdog counter runs in all x_WAIT and TAG_WAIT states and resets on every state change. Reaching TIMEOUT_CYCLES raises err code 3.
- ERR: all valids low, in_ready low; return to IDLE next cycle. tag_valid never pulses for an errored message.
- abort in any non-IDLE state: go to IDLE next cycle, drop all valids, no err pulse. abort in IDLE is ignored. abort wins over simultaneous handshakes.
- start while busy is ignored.
- Done pulses arriving in a non-matching state are ignored.

## Timing
- Reset values:
  - All outputs 0: valids, keeps, data, len_block, tag_out, tag_valid, err, err_code, busy, in_ready, adp_start.
  - adp_algo_sel is 1.
  - State is IDLE, counters are 0.
- Outputs are registered except in_ready, which is decoded combinationally from state.
- Latency:
  - start → adp_start: 1 cycle.
  - in handshake → x_valid: 1 cycle.
  - tag_in_valid → tag_valid: 1 cycle.
- Reset asserted mid-message clears everything asynchronously. There is no recovery handshake; the engine is also reset.
- Lengths are taken modulo 2^32. Block counts are ceil(len/16).

## Structure
- Shared package: state encoding, err_code constants, BLOCK_BYTES=16, and a function keep_from_count(n).
- One natural sub-module is block_masker (count → keep, data zeroing), which is combinational and also reused by the GCM path.

## Test plan
- aad_len=16, pld_len=32, done pulses 5 cycles after each handshake:
  - 1 AAD block with keep FFFF, then 2 PLD blocks with keep FFFF.
  - len_block = 0x00000000_00000020_00000000_00000010.
  - One tag_valid; busy falls after DONE.
- aad_len=5, pld_len=20, in_data all 0xFF:
  - AAD keep 001F with bytes 5-15 zero.
  - PLD keeps FFFF then 000F with bytes 4-15 zero.
- aad_len=0: err pulse with code 0; adp_start, busy and valids stay 0.
- pld_len=32 with in_last on the first payload beat: err code 1, pld_valid never asserted, IDLE after 2 cycles.
- TIMEOUT_CYCLES=8 and aad_done withheld: err code 3 exactly 8 cycles after entering AAD_WAIT.
- abort while pld_valid is high and pld_ready is low: pld_valid drops next cycle, no err, no tag_valid; a new start then completes normally.
